// File: rtl/reset_pkg.sv
// Shared definitions for the reset sequencer: FSM states, reset-cause codes
// and the counter-width rule used by the sequencer.
package reset_pkg;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } seq_state_e;

   localparam logic [1:0] CAUSE_POR    = 2'b01;
   localparam logic [1:0] CAUSE_BUTTON = 2'b10;
   localparam logic [1:0] CAUSE_SOFT   = 2'b11;

   // Wide enough for the longest interval any counter must represent.
   function automatic int cnt_width(input int hold, input int debounce, input int stagger_total);
      int m;
      m = hold;
      if (debounce > m) m = debounce;
      if (stagger_total > m) m = stagger_total;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/reset_debounce.sv
// Two-flop synchroniser plus level debouncer for the active-low reset button.
// pressed is high while the accepted (debounced) button level is low.
module reset_debounce #(
   parameter int DEBOUNCE_CYCLES = 65536
) (
   input  logic clk,
   input  logic reset,
   input  logic in_n,
   output logic pressed
);

   localparam int             DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic            sync1_q;
   logic            sync2_q;
   logic            level_q;
   logic [DB_W-1:0] cnt_q;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would collapse the synchroniser chain.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         cnt_q   <= '0;
      end else begin
         sync1_q <= in_n;
         sync2_q <= sync1_q;
         // Count consecutive samples that disagree with the accepted level.
         if (sync2_q == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == DB_LAST) begin
            level_q <= sync2_q;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign pressed = ~level_q;

endmodule

// File: rtl/reset_sequencer.sv
// Holds all reset domains after a POR, button or soft trigger, then releases
// them one at a time, lowest index first, before reporting ready.
module reset_sequencer
   import reset_pkg::*;
#(
   parameter int NUM_DOMAINS     = 4,
   parameter int HOLD_CYCLES     = 5000000,
   parameter int STAGGER_CYCLES  = 16,
   parameter int DEBOUNCE_CYCLES = 65536
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   fpga_but1,
   input  logic                   sw_req,
   output logic [NUM_DOMAINS-1:0] rst_n,
   output logic                   ready,
   output logic [1:0]             cause
);

   localparam int CNT_W = cnt_width(HOLD_CYCLES, DEBOUNCE_CYCLES, NUM_DOMAINS * STAGGER_CYCLES);
   localparam logic [CNT_W-1:0]       HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]       STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
   localparam logic [NUM_DOMAINS-1:0] FIRST_DOM = NUM_DOMAINS'(1);

   seq_state_e             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [NUM_DOMAINS-1:0] rst_n_q, rst_n_d;
   logic                   ready_q, ready_d;
   logic [1:0]             cause_q, cause_d;
   logic                   por_gate_q;
   logic                   btn_pressed;

   reset_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .in_n   (fpga_but1),
      .pressed(btn_pressed)
   );

   // NOTE: every next-state signal gets a default before any branch, so no
   // path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rst_n_d = rst_n_q;
      ready_d = ready_q;
      cause_d = cause_q;
      if (btn_pressed) begin
         state_d = ST_HOLD;
         cnt_d   = '0;
         rst_n_d = '0;
         ready_d = 1'b0;
         cause_d = CAUSE_BUTTON;
      end else if (sw_req && state_q != ST_HOLD) begin
         state_d = ST_HOLD;
         cnt_d   = '0;
         rst_n_d = '0;
         ready_d = 1'b0;
         cause_d = CAUSE_SOFT;
      end else begin
         case (state_q)
            ST_HOLD: begin
               // The first edge after POR aligns with a trigger edge, so it does not count.
               if (por_gate_q) begin
                  cnt_d = '0;
               end else if (cnt_q == HOLD_LAST) begin
                  cnt_d   = '0;
                  rst_n_d = (rst_n_q << 1) | FIRST_DOM;
                  ready_d = &rst_n_d;
                  state_d = ready_d ? ST_RUN : ST_RELEASE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_RELEASE: begin
               if (cnt_q == STAG_LAST) begin
                  cnt_d   = '0;
                  rst_n_d = (rst_n_q << 1) | FIRST_DOM;
                  ready_d = &rst_n_d;
                  state_d = ready_d ? ST_RUN : ST_RELEASE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_RUN: ;
            default: state_d = ST_HOLD;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_HOLD;
         cnt_q      <= '0;
         rst_n_q    <= '0;
         ready_q    <= 1'b0;
         cause_q    <= CAUSE_POR;
         por_gate_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rst_n_q    <= rst_n_d;
         ready_q    <= ready_d;
         cause_q    <= cause_d;
         por_gate_q <= 1'b0;
      end
   end

   assign rst_n = rst_n_q;
   assign ready = ready_q;
   assign cause = cause_q;

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_DOMAINS, default 4, meaning the number of reset domains released in sequence (legal 1..8).
REQ-002 SHALL have parameter HOLD_CYCLES, default 5000000, meaning the cycles all domains are held after the last reset trigger (legal >=2).
REQ-003 SHALL have parameter STAGGER_CYCLES, default 16, meaning the cycles between consecutive domain releases (legal >=1).
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 65536, meaning the consecutive stable cycles needed to accept a button level change (legal >=2).
REQ-005 SHALL have port clk, input, 1 bit: the single system clock.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high power-on reset (fpga_start-derived).
REQ-007 SHALL have port fpga_but1, input, 1 bit: asynchronous, active-low reset button.
REQ-008 SHALL have port sw_req, input, 1 bit: single-cycle soft reset request from logic.
REQ-009 SHALL have port rst_n, output, NUM_DOMAINS bits: active-low per-domain reset; bit 0 is released first.
REQ-010 SHALL have port ready, output, 1 bit: high when all domains are released.
REQ-011 SHALL have port cause, output, 2 bits: source of the last reset (01 POR, 10 BUTTON, 11 SOFT).

Function
REQ-012 SHALL implement states HOLD, RELEASE and RUN, with all outputs registered.
REQ-013 SHALL count hold cycles in HOLD, moving to RELEASE when the count reaches HOLD_CYCLES-1.
REQ-014 SHALL drive rst_n[k] high at edge HOLD_CYCLES + k*STAGGER_CYCLES, where edge 0 is the first edge sampling reset=0 or the trigger edge.
REQ-015 SHALL keep a released rst_n bit high until the next trigger (monotonic release).
REQ-016 SHALL raise ready and enter RUN on the same edge that releases rst_n[NUM_DOMAINS-1].
REQ-017 SHALL pass fpga_but1 through a 2-FF synchroniser, then accept a level only after DEBOUNCE_CYCLES consecutive equal synchronised samples.
REQ-018 SHALL, on a debounced press, drive all rst_n=0 and ready=0 on the next edge, enter HOLD with count 0, and set cause=10.
REQ-019 SHALL keep the hold count at 0 while the debounced button remains pressed; counting starts on the debounced release.
REQ-020 SHALL, on sw_req=1 in RELEASE or RUN, drive all rst_n=0 on the next edge, enter HOLD with count 0, and set cause=11.
REQ-021 SHALL ignore sw_req while in HOLD.
REQ-022 SHALL treat a button press or sw_req during RELEASE as a full restart: all domains are re-asserted and the hold count restarts.
REQ-023 SHALL resolve simultaneous triggers with priority reset > button > sw_req, and update cause only from the winner.
REQ-024 SHALL size counters at CNT_W = clog2(max(HOLD_CYCLES, DEBOUNCE_CYCLES, NUM_DOMAINS*STAGGER_CYCLES)+1), with no wrap-around in any state.

Reset
REQ-025 SHALL, while reset=1, force rst_n=0, ready=0, cause=01, state HOLD, all counters 0, and debounced button state = released.
REQ-026 SHALL restart the full HOLD/RELEASE sequence when reset is asserted mid-RELEASE or in RUN, with no glitch high on any rst_n.
REQ-027 SHALL preset the synchroniser flops to 1 (released) on reset.

Structure
REQ-028 SHALL place the state enum (HOLD/RELEASE/RUN) and the cause encodings in shared package reset_pkg.
REQ-029 SHALL implement the synchroniser and debouncer as sub-module reset_debounce (parameter DEBOUNCE_CYCLES; ports clk, reset, in_n, pressed).
REQ-030 SHALL be implementable in 120-400 lines of RTL, including reset_debounce.

Verification
(Parameters: NUM_DOMAINS=3, HOLD_CYCLES=20, STAGGER_CYCLES=4, DEBOUNCE_CYCLES=8.)
REQ-031 SHALL check: reset high for 5 cycles then low -> rst_n=000 through edge 19, 001 at edge 20, 011 at edge 24, 111 and ready=1 at edge 28, cause=01.
REQ-032 SHALL check: fpga_but1 low for 30 cycles in RUN -> rst_n=000 and cause=10 within 2+8+1 edges of the fall; the hold ends 20 edges after the debounced release; then rst_n=111 after 8 more edges.
REQ-033 SHALL check: fpga_but1 glitch low for 5 cycles -> no change to rst_n, ready or cause.
REQ-034 SHALL check: sw_req pulse at edge 25 (rst_n=011) -> rst_n=000 at edge 26, cause=11, full sequence repeats; a sw_req pulse in HOLD is ignored.
REQ-035 SHALL check: reset and a debounced press on the same edge -> cause=01; sw_req and a debounced press on the same edge -> cause=10.
